io_mmio_uart: RTL and testbench

IO_MMIO_UART -- requirements
Module: io_mmio_uart

---
 rtl/io_mmio_pkg.sv | 27 ++
 rtl/io_fifo.sv | 52 +++++
 rtl/uart.sv | 84 ++++++++
 rtl/io_mmio_uart.sv | 109 ++++++++++
 tb/tb_io_mmio_uart.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/io_mmio_pkg.sv
// Shared register map and bit positions for the memory-mapped UART block.
package io_mmio_pkg;

  typedef enum logic [3:0] {
    REG_STATUS  = 4'h0,
    REG_RXDATA  = 4'h4,
    REG_TXDATA  = 4'h8,
    REG_CONTROL = 4'hC
  } reg_off_e;

  localparam int ST_TX_NOT_FULL  = 0;
  localparam int ST_RX_NOT_EMPTY = 1;
  localparam int ST_RX_OVERFLOW  = 2;
  localparam int ST_TX_DROP      = 3;
  localparam int ST_TX_IDLE      = 4;
  localparam int ST_RX_CNT_LSB   = 8;
  localparam int ST_TX_CNT_LSB   = 16;

  localparam int CTRL_CLR_STICKY = 0;
  localparam int CTRL_FLUSH      = 1;

  // A 256-deep FIFO holds 256 entries, which does not fit the 8-bit field; saturate.
  function automatic logic [7:0] cnt_field(input logic [8:0] c);
    return c[8] ? 8'hFF : c[7:0];
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO; push is accepted when full if a pop happens on the same edge.
module io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop_ok, w_push_ok;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_pop_ok  = pop & ~empty;
  assign w_push_ok = push & (~full | w_pop_ok);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart.sv
// Existing 8N1 UART core: ready/valid byte interface on both directions.
module uart #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] DataIn,
  input  logic       DataInValid,
  output logic       DataInReady,
  output logic [7:0] DataOut,
  output logic       DataOutValid,
  input  logic       DataOutReady,
  input  logic       SIn,
  output logic       SOut
);

  localparam int BIT_T = CLK_HZ / BAUD;
  localparam int TW    = $clog2(BIT_T + 1);
  localparam logic [TW-1:0] T_LAST = TW'(BIT_T - 1);
  localparam logic [TW-1:0] T_HALF = TW'(BIT_T / 2 - 1);

  logic [9:0]    r_tx_shift, r_rx_shift;
  logic [3:0]    r_tx_bits, r_rx_bits;
  logic [TW-1:0] r_tx_tmr, r_rx_tmr;
  logic          r_sin1, r_sin2, r_rx_valid;
  logic          w_unused_frame;

  assign DataInReady    = (r_tx_bits == 4'd0);
  assign SOut           = (r_tx_bits == 4'd0) | r_tx_shift[0];
  assign DataOut        = r_rx_shift[8:1];
  assign DataOutValid   = r_rx_valid;
  assign w_unused_frame = r_rx_shift[0] ^ r_rx_shift[9];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_shift <= '1;
      r_tx_bits  <= '0;
      r_tx_tmr   <= '0;
    end else if (DataInValid && DataInReady) begin
      r_tx_shift <= {1'b1, DataIn, 1'b0};
      r_tx_bits  <= 4'd10;
      r_tx_tmr   <= '0;
    end else if (r_tx_bits != 4'd0) begin
      if (r_tx_tmr == T_LAST) begin
        r_tx_tmr   <= '0;
        r_tx_shift <= {1'b1, r_tx_shift[9:1]};
        r_tx_bits  <= r_tx_bits - 4'd1;
      end else begin
        r_tx_tmr <= r_tx_tmr + 1'b1;
      end
    end
  end

  // Receiver waits half a bit after the start edge, then samples at bit centres.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sin1     <= 1'b1;
      r_sin2     <= 1'b1;
      r_rx_shift <= '0;
      r_rx_bits  <= '0;
      r_rx_tmr   <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_sin1 <= SIn;
      r_sin2 <= r_sin1;
      if (r_rx_valid && DataOutReady) r_rx_valid <= 1'b0;
      if (r_rx_bits == 4'd0) begin
        if (!r_sin2) begin
          r_rx_bits <= 4'd10;
          r_rx_tmr  <= T_HALF;
        end
      end else if (r_rx_tmr == '0) begin
        r_rx_shift <= {r_sin2, r_rx_shift[9:1]};
        r_rx_bits  <= r_rx_bits - 4'd1;
        r_rx_tmr   <= T_LAST;
        if (r_rx_bits == 4'd1) r_rx_valid <= 1'b1;
      end else begin
        r_rx_tmr <= r_rx_tmr - 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_mmio_uart.sv
// 16-byte MMIO window around the UART core with RX/TX byte FIFOs and sticky error flags.
module io_mmio_uart
  import io_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h80000000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          CLK_HZ     = 50_000_000,
  parameter int          BAUD       = 115_200
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  input  logic [3:0]  IO_trans,
  input  logic        IO_recv,
  input  logic        FPGA_Sin,
  output logic        FPGA_Sout,
  output logic [31:0] Received
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          w_hit, w_rd, w_wr, w_tx_wr, w_ctrl_wr, w_clr, w_flush;
  logic [3:0]    w_off;
  logic [7:0]    w_tx_dout, w_rx_dout, w_uart_dout;
  logic [CW-1:0] w_tx_count, w_rx_count;
  logic          w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic          w_tx_valid, w_tx_pop, w_rx_pop, w_uart_in_ready, w_uart_out_valid;
  logic          w_tx_drop_evt, w_rx_ovf_evt;
  logic          r_rx_ovf, r_tx_drop;
  logic [31:0]   w_status, w_rdata;
  logic          w_unused_bits;

  assign w_hit     = (Addr[31:4] == BASE_ADDR[31:4]);
  assign w_off     = Addr[3:0];
  assign w_rd      = IO_recv & ~IO_trans[0];
  assign w_wr      = IO_trans[0] & ~IO_recv;
  assign w_tx_wr   = w_wr & w_hit & (w_off == REG_TXDATA);
  assign w_ctrl_wr = w_wr & w_hit & (w_off == REG_CONTROL);
  assign w_clr     = w_ctrl_wr & WData[CTRL_CLR_STICKY];
  assign w_flush   = w_ctrl_wr & WData[CTRL_FLUSH];
  assign w_rx_pop  = w_rd & w_hit & (w_off == REG_RXDATA) & ~w_rx_empty;

  assign w_tx_valid    = ~w_tx_empty;
  assign w_tx_pop      = w_tx_valid & w_uart_in_ready;
  assign w_tx_drop_evt = w_tx_wr & w_tx_full & ~w_tx_pop;
  assign w_rx_ovf_evt  = w_uart_out_valid & w_rx_full & ~w_rx_pop;
  assign w_unused_bits = ^{WData[31:8], IO_trans[3:1]};

  io_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(Clock), .rst(Reset), .push(w_tx_wr), .pop(w_tx_pop), .flush(w_flush),
    .din(WData[7:0]), .dout(w_tx_dout), .count(w_tx_count),
    .full(w_tx_full), .empty(w_tx_empty)
  );

  io_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(Clock), .rst(Reset), .push(w_uart_out_valid), .pop(w_rx_pop), .flush(w_flush),
    .din(w_uart_dout), .dout(w_rx_dout), .count(w_rx_count),
    .full(w_rx_full), .empty(w_rx_empty)
  );

  uart #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_uart (
    .clk(Clock), .reset(Reset),
    .DataIn(w_tx_dout), .DataInValid(w_tx_valid), .DataInReady(w_uart_in_ready),
    .DataOut(w_uart_dout), .DataOutValid(w_uart_out_valid), .DataOutReady(1'b1),
    .SIn(FPGA_Sin), .SOut(FPGA_Sout)
  );

  // A new event on the same edge as a clear wins, so no error is lost.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_rx_ovf  <= 1'b0;
      r_tx_drop <= 1'b0;
    end else begin
      if (w_rx_ovf_evt)  r_rx_ovf <= 1'b1;
      else if (w_clr)    r_rx_ovf <= 1'b0;
      if (w_tx_drop_evt) r_tx_drop <= 1'b1;
      else if (w_clr)    r_tx_drop <= 1'b0;
    end
  end

  always_comb begin
    w_status                           = '0;
    w_status[ST_TX_NOT_FULL]           = ~w_tx_full;
    w_status[ST_RX_NOT_EMPTY]          = ~w_rx_empty;
    w_status[ST_RX_OVERFLOW]           = r_rx_ovf;
    w_status[ST_TX_DROP]               = r_tx_drop;
    w_status[ST_TX_IDLE]               = w_tx_empty & w_uart_in_ready;
    w_status[ST_RX_CNT_LSB +: 8]       = cnt_field(9'(w_rx_count));
    w_status[ST_TX_CNT_LSB +: 8]       = cnt_field(9'(w_tx_count));
  end

  always_comb begin
    w_rdata = '0;
    if (w_hit) begin
      case (w_off)
        REG_STATUS: w_rdata = w_status;
        REG_RXDATA: if (!w_rx_empty) w_rdata = {24'h0, w_rx_dout};
        default:    w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset)     Received <= '0;
    else if (w_rd) Received <= w_rdata;
  end

endmodule

// File: tb/tb_io_mmio_uart.sv
// Directed bench: register-access vector table plus serial TX/RX sequences.
module tb_io_mmio_uart;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] A_ST = BASE + 32'h0;
  localparam logic [31:0] A_RX = BASE + 32'h4;
  localparam logic [31:0] A_TX = BASE + 32'h8;
  localparam logic [31:0] A_CT = BASE + 32'hC;
  localparam int BT = 10;

  logic        Clock = 1'b0, Reset = 1'b1;
  logic [31:0] Addr = '0, WData = '0;
  logic [3:0]  IO_trans = '0;
  logic        IO_recv = 1'b0, FPGA_Sin = 1'b1;
  logic        FPGA_Sout;
  logic [31:0] Received;

  int n_checks = 0, n_fail = 0;
  logic [7:0] txq[$];
  logic [7:0] mon_b;

  always #5 Clock = ~Clock;

  io_mmio_uart #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .CLK_HZ(1_000_000), .BAUD(100_000)) dut (
    .Clock(Clock), .Reset(Reset), .Addr(Addr), .WData(WData), .IO_trans(IO_trans),
    .IO_recv(IO_recv), .FPGA_Sin(FPGA_Sin), .FPGA_Sout(FPGA_Sout), .Received(Received)
  );

  // Serial line monitor: decode 8N1 frames seen on FPGA_Sout.
  always begin : tx_mon
    @(negedge FPGA_Sout);
    repeat (BT + BT / 2) @(posedge Clock);
    for (int i = 0; i < 8; i++) begin
      mon_b[i] = FPGA_Sout;
      repeat (BT) @(posedge Clock);
    end
    txq.push_back(mon_b);
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    Addr = a; IO_recv = 1'b1; IO_trans = 4'h0;
    @(negedge Clock);
    IO_recv = 1'b0;
    d = Received;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] dv);
    Addr = a; WData = dv; IO_trans = 4'h1; IO_recv = 1'b0;
    @(negedge Clock);
    IO_trans = 4'h0;
  endtask

  task automatic wait_idle(input int maxr);
    logic [31:0] d;
    for (int i = 0; i < maxr; i++) begin
      rd(A_ST, d);
      if (d[4]) break;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      FPGA_Sin = fr[i];
      cyc(BT);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[15];
  logic [31:0] d;
  int lows;

  initial begin
    vt[0]  = '{A_ST,            32'h0,  1'b1, 1'b0, 32'h11};
    vt[1]  = '{A_RX,            32'h0,  1'b1, 1'b0, 32'h0};
    vt[2]  = '{A_ST,            32'h0,  1'b1, 1'b0, 32'h11};
    vt[3]  = '{A_TX,            32'h0,  1'b1, 1'b0, 32'h0};
    vt[4]  = '{A_ST,            32'h0,  1'b1, 1'b0, 32'h11};
    vt[5]  = '{A_CT,            32'h0,  1'b1, 1'b0, 32'h0};
    vt[6]  = '{A_ST,            32'h0,  1'b1, 1'b0, 32'h11};
    vt[7]  = '{BASE + 32'h10,   32'h0,  1'b1, 1'b0, 32'h0};
    vt[8]  = '{A_ST,            32'h0,  1'b1, 1'b0, 32'h11};
    vt[9]  = '{A_TX,            32'h55, 1'b1, 1'b1, 32'h11};
    vt[10] = '{A_ST,            32'h0,  1'b1, 1'b0, 32'h11};
    vt[11] = '{32'h0000_0000,   32'h0,  1'b1, 1'b0, 32'h0};
    vt[12] = '{A_CT,            32'h3,  1'b0, 1'b1, 32'h0};
    vt[13] = '{A_ST,            32'h0,  1'b1, 1'b0, 32'h11};
    vt[14] = '{BASE + 32'h2,    32'h0,  1'b1, 1'b0, 32'h0};

    @(negedge Clock);
    cyc(3);
    Reset = 1'b0;
    chk("reset Received", Received, 32'h0);
    chk("reset Sout", {31'h0, FPGA_Sout}, 32'h1);

    foreach (vt[i]) begin
      Addr = vt[i].addr; WData = vt[i].wdata;
      IO_recv = vt[i].rd; IO_trans = {3'b0, vt[i].wr};
      @(negedge Clock);
      IO_recv = 1'b0; IO_trans = 4'h0;
      chk($sformatf("vec%0d", i), Received, vt[i].exp);
    end

    // Three bytes out in order, then idle.
    wr(A_TX, 32'h41); wr(A_TX, 32'h42); wr(A_TX, 32'h43);
    rd(A_ST, d);
    chk("tx3 busy status", d, 32'h0002_0001);
    wait_idle(600);
    rd(A_ST, d);
    chk("tx3 idle status", d, 32'h11);
    cyc(5);
    chk("tx3 frame count", txq.size(), 3);
    if (txq.size() == 3) begin
      chk("tx3 byte0", {24'h0, txq[0]}, 32'h41);
      chk("tx3 byte1", {24'h0, txq[1]}, 32'h42);
      chk("tx3 byte2", {24'h0, txq[2]}, 32'h43);
    end

    // UART busy with a lead byte, then a 9-byte burst overruns the 8-entry FIFO.
    txq.delete();
    wr(A_TX, 32'h50);
    cyc(5);
    for (int i = 0; i < 9; i++) wr(A_TX, 32'h60 + i);
    rd(A_ST, d);
    chk("tx full+drop status", d, 32'h0008_0008);
    wr(A_CT, 32'h1);
    rd(A_ST, d);
    chk("tx drop cleared", d, 32'h0008_0000);
    wait_idle(1200);
    rd(A_ST, d);
    chk("tx burst idle", d, 32'h11);
    cyc(5);
    chk("tx burst frames", txq.size(), 9);
    if (txq.size() == 9) begin
      chk("tx burst lead", {24'h0, txq[0]}, 32'h50);
      for (int i = 1; i < 9; i++)
        chk($sformatf("tx burst byte%0d", i), {24'h0, txq[i]}, 32'h60 + i - 1);
    end

    // Flush drops queued bytes but not the one already in the UART.
    txq.delete();
    wr(A_TX, 32'h70);
    cyc(3);
    wr(A_TX, 32'h71); wr(A_TX, 32'h72);
    rd(A_ST, d);
    chk("flush pre status", d, 32'h0002_0001);
    wr(A_CT, 32'h2);
    rd(A_ST, d);
    chk("flush post status", d, 32'h0000_0001);
    wait_idle(300);
    cyc(5);
    chk("flush frames", txq.size(), 1);
    if (txq.size() == 1) chk("flush byte", {24'h0, txq[0]}, 32'h70);

    // Nine received frames with no reads: eight kept, overflow flagged.
    for (int i = 0; i < 9; i++) begin
      send_byte(8'h31 + 8'(i));
      cyc(4);
    end
    rd(A_ST, d);
    chk("rx overflow status", d, 32'h0000_0817);

    // Pop on the exact edge the tenth byte is pushed into the full FIFO.
    wr(A_CT, 32'h1);
    fork
      send_byte(8'h3A);
      begin
        logic [31:0] dd;
        cyc(98);
        rd(A_RX, dd);
        chk("rx pop+push head", dd, 32'h31);
      end
    join
    cyc(4);
    rd(A_ST, d);
    chk("rx pop+push status", d, 32'h0000_0813);
    for (int i = 1; i < 8; i++) begin
      rd(A_RX, d);
      chk($sformatf("rx byte%0d", i), d, 32'h31 + i);
    end
    rd(A_RX, d);
    chk("rx late byte", d, 32'h3A);
    rd(A_RX, d);
    chk("rx empty read", d, 32'h0);
    rd(A_ST, d);
    chk("rx drained status", d, 32'h11);

    // Reset in the middle of a transmitted frame.
    wr(A_TX, 32'h55); wr(A_TX, 32'h56);
    cyc(45);
    Reset = 1'b1;
    @(negedge Clock);
    chk("midframe reset Sout", {31'h0, FPGA_Sout}, 32'h1);
    chk("midframe reset Received", Received, 32'h0);
    Reset = 1'b0;
    rd(A_ST, d);
    chk("midframe reset status", d, 32'h11);
    cyc(120);
    txq.delete();
    lows = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge Clock);
      if (!FPGA_Sout) lows++;
    end
    chk("post reset line idle", lows, 0);
    chk("post reset no frames", txq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
